// File: rtl/systolic_ctrl_if.sv
// Activation input stream and result output stream between the host side and systolic_ctrl.
interface systolic_ctrl_if #(
  parameter int unsigned N   = 2,
  parameter int unsigned DW  = 8,
  parameter int unsigned PSW = 24
);
  logic             act_valid;
  logic             act_ready;
  logic [N*DW-1:0]  act_vec;
  logic             act_last;
  logic             res_valid;
  logic [N*PSW-1:0] res_vec;

  modport master (output act_valid, act_vec, act_last, input act_ready, res_valid, res_vec);
  modport slave  (input act_valid, act_vec, act_last, output act_ready, res_valid, res_vec);
endinterface

// File: rtl/systolic_ctrl.sv
// Weight-stationary systolic array sequencer: loads weights bottom row first, skews
// activations onto the left edge and de-skews bottom-row partial sums into result vectors.
module systolic_ctrl #(
  parameter int unsigned N   = 2,
  parameter int unsigned DW  = 8,
  parameter int unsigned PSW = 24
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [N*N*DW-1:0]  w_mat,
  output logic               busy,
  output logic               done,
  systolic_ctrl_if.slave     act,
  output logic [N-1:0]       mac_reset,
  output logic [N*DW-1:0]    w_out,
  output logic [N*DW-1:0]    a_out,
  input  logic [N*PSW-1:0]   ps_in
);
  localparam int unsigned CW   = (N > 1) ? $clog2(N) : 1;
  localparam int unsigned ROWW = N * DW;
  localparam int unsigned TD   = 2 * N;

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] LOAD   = 3'd1;
  localparam logic [2:0] STREAM = 3'd2;
  localparam logic [2:0] DRAIN  = 3'd3;
  localparam logic [2:0] DONE   = 3'd4;

  logic [2:0]         state, state_d;
  logic [CW-1:0]      cnt, cnt_d;
  logic [N*N*DW-1:0]  w_reg, w_src;
  logic               busy_d, done_d, ready_d, ready_q;
  logic [N-1:0]       mac_reset_d;
  logic [ROWW-1:0]    w_out_d, inject;
  logic [TD-1:0]      tags;
  logic               res_valid_q;
  logic [N*PSW-1:0]   res_vec_q;
  logic               xfer;

  assign xfer          = act.act_valid & ready_q;
  assign inject        = xfer ? act.act_vec : '0;
  // The first LOAD row must come straight from w_mat since w_reg captures on the same edge.
  assign w_src         = (state == IDLE) ? w_mat : w_reg;
  assign act.act_ready = ready_q;
  assign act.res_valid = res_valid_q;
  assign act.res_vec   = res_vec_q;

  // Next state, then registered-output values decoded from the next state.
  always_comb begin
    state_d     = state;
    cnt_d       = cnt;
    busy_d      = 1'b0;
    done_d      = 1'b0;
    ready_d     = 1'b0;
    mac_reset_d = '1;
    w_out_d     = '0;
    case (state)
      IDLE:    if (start) begin
                 state_d = LOAD;
                 cnt_d   = '0;
               end
      LOAD:    if (cnt == CW'(N - 1)) state_d = STREAM;
               else                   cnt_d   = cnt + CW'(1);
      STREAM:  if (xfer && act.act_last) state_d = DRAIN;
      DRAIN:   if (tags == '0) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    case (state_d)
      LOAD: begin
        busy_d = 1'b1;
        for (int i = 0; i < N; i++) mac_reset_d[i] = (CW'(i) > cnt_d);
        w_out_d = w_src[(N - 1 - int'(cnt_d)) * ROWW +: ROWW];
      end
      STREAM: begin
        busy_d      = 1'b1;
        ready_d     = 1'b1;
        mac_reset_d = '0;
      end
      DRAIN: begin
        busy_d      = 1'b1;
        mac_reset_d = '0;
      end
      DONE: begin
        done_d      = 1'b1;
        mac_reset_d = '0;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      cnt         <= '0;
      w_reg       <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      ready_q     <= 1'b0;
      mac_reset   <= '1;
      w_out       <= '0;
      tags        <= '0;
      res_valid_q <= 1'b0;
    end else begin
      state       <= state_d;
      cnt         <= cnt_d;
      busy        <= busy_d;
      done        <= done_d;
      ready_q     <= ready_d;
      mac_reset   <= mac_reset_d;
      w_out       <= w_out_d;
      if (state == IDLE && start) w_reg <= w_mat;
      tags        <= {tags[TD-2:0], xfer};
      res_valid_q <= tags[TD-1];
    end
  end

  // Row i gets i+1 registers, so row i trails row 0 by i cycles.
  for (genvar i = 0; i < N; i++) begin : g_skew
    logic [DW-1:0] sr [0:i];
    always_ff @(posedge clk) begin
      if (reset) begin
        for (int k = 0; k <= i; k++) sr[k] <= '0;
      end else begin
        sr[0] <= inject[i*DW +: DW];
        for (int k = 1; k <= i; k++) sr[k] <= sr[k-1];
      end
    end
    assign a_out[i*DW +: DW] = sr[i];
  end

  // Column j: N-1-j alignment stages plus the output register.
  for (genvar j = 0; j < N; j++) begin : g_deskew
    localparam int unsigned D = N - 1 - j;
    logic [PSW-1:0] dl [0:D];
    always_ff @(posedge clk) begin
      if (reset) begin
        for (int k = 0; k <= D; k++) dl[k] <= '0;
      end else begin
        dl[0] <= ps_in[j*PSW +: PSW];
        for (int k = 1; k <= D; k++) dl[k] <= dl[k-1];
      end
    end
    assign res_vec_q[j*PSW +: PSW] = dl[D];
  end
endmodule

// File: tb/tb_systolic_ctrl.sv
// Bench for systolic_ctrl: per-cycle vector table for a full job plus bubble, reset and wrap sequences.
module tb_systolic_ctrl;
  localparam int unsigned N   = 2;
  localparam int unsigned DW  = 8;
  localparam int unsigned PSW = 24;

  logic               clk = 1'b0;
  logic               reset;
  logic               start;
  logic [N*N*DW-1:0]  w_mat;
  logic               busy, done;
  logic [N-1:0]       mac_reset;
  logic [N*DW-1:0]    w_out, a_out;
  logic [N*PSW-1:0]   ps_in;

  systolic_ctrl_if #(.N(N), .DW(DW), .PSW(PSW)) io ();

  systolic_ctrl #(.N(N), .DW(DW), .PSW(PSW)) dut (
    .clk(clk), .reset(reset), .start(start), .w_mat(w_mat),
    .busy(busy), .done(done), .act(io.slave), .mac_reset(mac_reset),
    .w_out(w_out), .a_out(a_out), .ps_in(ps_in)
  );

  always #5 clk = ~clk;

  // Array model: MAC(i,j) sees a_out[i] j cycles late; bottom sum registered once per row.
  logic [DW-1:0]   wm [N][N];
  logic [N*DW-1:0] hist [0:2*N-1];

  always @(posedge clk) begin
    if (reset) begin
      for (int k = 0; k < 2*N; k++) hist[k] <= '0;
    end else begin
      for (int k = 2*N-1; k > 0; k--) hist[k] <= hist[k-1];
      hist[0] <= a_out;
    end
  end

  logic [PSW-1:0] msum;
  int             mdel;
  always_comb begin
    ps_in = '0;
    msum  = '0;
    mdel  = 0;
    for (int j = 0; j < N; j++) begin
      msum = '0;
      for (int i = 0; i < N; i++) begin
        mdel = j + int'(N) - i;
        msum = msum + PSW'(wm[i][j]) * PSW'(hist[mdel-1][i*DW +: DW]);
      end
      ps_in[j*PSW +: PSW] = msum;
    end
  end

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int rv_cyc[$];
  logic [N*PSW-1:0] rv_val[$];
  int done_cyc[$];

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  function automatic logic [N*DW-1:0] pa(input int a0, input int a1);
    return {DW'(a1), DW'(a0)};
  endfunction

  function automatic logic [N*PSW-1:0] pp(input int p0, input int p1);
    return {PSW'(p1), PSW'(p0)};
  endfunction

  function automatic logic [N*N*DW-1:0] pack_w();
    logic [N*N*DW-1:0] w;
    w = '0;
    for (int r = 0; r < N; r++)
      for (int c = 0; c < N; c++) w[(r*N+c)*DW +: DW] = wm[r][c];
    return w;
  endfunction

  task automatic tick();
    @(negedge clk);
    cyc++;
    if (io.res_valid) begin
      rv_cyc.push_back(cyc);
      rv_val.push_back(io.res_vec);
    end
    if (done) done_cyc.push_back(cyc);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    start = 1'b0;
    io.act_valid = 1'b0;
    io.act_last  = 1'b0;
    io.act_vec   = '0;
    w_mat = pack_w();
    repeat (2) @(negedge clk);
    reset = 1'b0;
    cyc = 0;
    rv_cyc.delete();
    rv_val.delete();
    done_cyc.delete();
  endtask

  task automatic finish_job();
    io.act_valid = 1'b0;
    io.act_last  = 1'b0;
    for (int k = 0; k < 20 && done_cyc.size() == 0; k++) tick();
  endtask

  typedef struct {
    logic             st;
    logic             av;
    logic [N*DW-1:0]  vec;
    logic             al;
    logic             e_busy;
    logic             e_done;
    logic             e_rdy;
    logic [N-1:0]     e_mr;
    logic [N*DW-1:0]  e_w;
    logic [N*DW-1:0]  e_a;
    logic             e_rv;
    logic [N*PSW-1:0] e_rvv;
  } vec_t;

  function automatic vec_t mk(input logic st, input logic av, input logic [N*DW-1:0] vec,
                              input logic al, input logic b, input logic d, input logic r,
                              input logic [N-1:0] mr, input logic [N*DW-1:0] w,
                              input logic [N*DW-1:0] a, input logic rv, input logic [N*PSW-1:0] rvv);
    vec_t t;
    t.st = st; t.av = av; t.vec = vec; t.al = al;
    t.e_busy = b; t.e_done = d; t.e_rdy = r; t.e_mr = mr;
    t.e_w = w; t.e_a = a; t.e_rv = rv; t.e_rvv = rvv;
    return t;
  endfunction

  vec_t tbl [12];

  initial begin
    // W row0=(9,6), row1=(4,10); one row per cycle starting in IDLE.
    tbl[0]  = mk(1, 0, pa(0,0), 0, 0, 0, 0, 2'b11, pa(0,0),  pa(0,0), 0, pp(0,0));
    tbl[1]  = mk(0, 1, pa(5,5), 1, 1, 0, 0, 2'b10, pa(4,10), pa(0,0), 0, pp(0,0));
    tbl[2]  = mk(1, 1, pa(5,5), 1, 1, 0, 0, 2'b00, pa(9,6),  pa(0,0), 0, pp(0,0));
    tbl[3]  = mk(0, 1, pa(2,7), 0, 1, 0, 1, 2'b00, pa(0,0),  pa(0,0), 0, pp(0,0));
    tbl[4]  = mk(1, 1, pa(3,1), 1, 1, 0, 1, 2'b00, pa(0,0),  pa(2,0), 0, pp(0,0));
    tbl[5]  = mk(0, 1, pa(8,8), 1, 1, 0, 0, 2'b00, pa(0,0),  pa(3,7), 0, pp(0,0));
    tbl[6]  = mk(0, 0, pa(0,0), 0, 1, 0, 0, 2'b00, pa(0,0),  pa(0,1), 0, pp(0,0));
    tbl[7]  = mk(0, 0, pa(0,0), 0, 1, 0, 0, 2'b00, pa(0,0),  pa(0,0), 0, pp(0,0));
    tbl[8]  = mk(0, 0, pa(0,0), 0, 1, 0, 0, 2'b00, pa(0,0),  pa(0,0), 1, pp(46,82));
    tbl[9]  = mk(0, 0, pa(0,0), 0, 1, 0, 0, 2'b00, pa(0,0),  pa(0,0), 1, pp(31,28));
    tbl[10] = mk(0, 0, pa(0,0), 0, 0, 1, 0, 2'b00, pa(0,0),  pa(0,0), 0, pp(0,0));
    tbl[11] = mk(0, 0, pa(0,0), 0, 0, 0, 0, 2'b11, pa(0,0),  pa(0,0), 0, pp(0,0));

    wm[0][0] = 8'd9; wm[0][1] = 8'd6; wm[1][0] = 8'd4; wm[1][1] = 8'd10;
    do_reset();
    chk("reset res_vec", io.res_vec, 0);
    chk("reset res_valid", io.res_valid, 0);

    for (int k = 0; k < 12; k++) begin
      tick();
      chk($sformatf("row%0d busy", k), busy, tbl[k].e_busy);
      chk($sformatf("row%0d done", k), done, tbl[k].e_done);
      chk($sformatf("row%0d act_ready", k), io.act_ready, tbl[k].e_rdy);
      chk($sformatf("row%0d mac_reset", k), mac_reset, tbl[k].e_mr);
      chk($sformatf("row%0d w_out", k), w_out, tbl[k].e_w);
      chk($sformatf("row%0d a_out", k), a_out, tbl[k].e_a);
      chk($sformatf("row%0d res_valid", k), io.res_valid, tbl[k].e_rv);
      if (tbl[k].e_rv) chk($sformatf("row%0d res_vec", k), io.res_vec, tbl[k].e_rvv);
      start        = tbl[k].st;
      io.act_valid = tbl[k].av;
      io.act_vec   = tbl[k].vec;
      io.act_last  = tbl[k].al;
      // Weights must come from the copy captured with start, not the live bus.
      w_mat        = (k == 0) ? pack_w() : '1;
    end

    // Two bubble cycles between the vectors.
    do_reset();
    tick(); start = 1'b1;
    tick(); start = 1'b0;
    tick();
    tick(); chk("bub act_ready", io.act_ready, 1);
    io.act_valid = 1'b1; io.act_vec = pa(2,7);
    tick(); io.act_valid = 1'b0;
    tick();
    tick(); io.act_valid = 1'b1; io.act_vec = pa(3,1); io.act_last = 1'b1;
    tick();
    finish_job();
    chk("bub res count", rv_cyc.size(), 2);
    chk("bub res0 cycle", (rv_cyc.size() > 0) ? rv_cyc[0] : -1, 9);
    chk("bub res1 cycle", (rv_cyc.size() > 1) ? rv_cyc[1] : -1, 12);
    chk("bub res0 vec", (rv_val.size() > 0) ? rv_val[0] : '0, pp(46,82));
    chk("bub res1 vec", (rv_val.size() > 1) ? rv_val[1] : '0, pp(31,28));
    chk("bub done count", done_cyc.size(), 1);
    chk("bub done cycle", (done_cyc.size() > 0) ? done_cyc[0] : -1, 13);

    // Reset one cycle after the first accepted vector.
    do_reset();
    tick(); start = 1'b1;
    tick(); start = 1'b0;
    tick();
    tick(); io.act_valid = 1'b1; io.act_vec = pa(2,7);
    tick(); io.act_valid = 1'b0; reset = 1'b1;
    tick(); reset = 1'b0;
    chk("rst mac_reset", mac_reset, 2'b11);
    chk("rst act_ready", io.act_ready, 0);
    chk("rst busy", busy, 0);
    chk("rst a_out", a_out, 0);
    chk("rst w_out", w_out, 0);
    rv_cyc.delete(); done_cyc.delete();
    repeat (12) tick();
    chk("rst no res_valid", rv_cyc.size(), 0);
    chk("rst no done", done_cyc.size(), 0);
    chk("rst still idle", mac_reset, 2'b11);

    // All-255 weights and activations: sums exceed DW bits and must not be truncated.
    for (int r = 0; r < N; r++) for (int c = 0; c < N; c++) wm[r][c] = 8'd255;
    do_reset();
    tick(); start = 1'b1;
    tick(); start = 1'b0;
    tick();
    tick(); io.act_valid = 1'b1; io.act_vec = pa(255,255); io.act_last = 1'b1;
    tick();
    finish_job();
    chk("wrap res count", rv_cyc.size(), 1);
    chk("wrap res cycle", (rv_cyc.size() > 0) ? rv_cyc[0] : -1, 9);
    chk("wrap res vec", (rv_val.size() > 0) ? rv_val[0] : '0, pp(130050,130050));
    chk("wrap done cycle", (done_cyc.size() > 0) ? done_cyc[0] : -1, 10);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
